// File: rtl/sonar_echo_detector.sv
// sonar_echo_detector
//
// Multi-channel sonar echo detector. A frame of N_CH signed PCM samples is
// accepted on a strobe. The channels are then processed one per cycle through
// a single shared multiplier: gain, absolute value, D-deep moving average,
// and threshold compare with hysteresis. A per-channel time-of-flight
// capture, counted in frames since the last ping, is reported on the first
// rising detection of each armed channel.
//
// Ports
//   clk           system clock
//   rst_n         asynchronous active-low reset
//   sample_valid  frame strobe, sample_i valid this cycle
//   sample_i      N_CH signed samples, channel k at [k*W +: W]
//   amp           signed gain shared by all channels
//   threshold     unsigned detection threshold (2W)
//   hyst          unsigned hysteresis amount (2W)
//   ping_start    clears ToF timer and sticky flags, arms all channels
//   ready         high in IDLE, a frame can be accepted
//   det_o         per-channel detection level
//   tof_valid     one-cycle pulse, new ToF capture
//   tof_ch        channel of the latest capture
//   tof_o         frame count of the latest capture
//   overrun       sticky, a frame arrived while busy and was dropped
//   timeout       sticky, the ToF timer saturated
//
// state | meaning
// IDLE  | waiting for a frame strobe; ready high
// PROC  | one channel per cycle through the shared multiplier
// DONE  | advance MAF write pointer and ToF timer, then back to IDLE
module sonar_echo_detector #(
  parameter int N_CH  = 4,
  parameter int W     = 16,
  parameter int LOG2D = 3,
  parameter int TW    = 16,
  localparam int CHW  = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              sample_valid,
  input  logic [N_CH*W-1:0] sample_i,
  input  logic [W-1:0]      amp,
  input  logic [2*W-1:0]    threshold,
  input  logic [2*W-1:0]    hyst,
  input  logic              ping_start,
  output logic              ready,
  output logic [N_CH-1:0]   det_o,
  output logic              tof_valid,
  output logic [CHW-1:0]    tof_ch,
  output logic [TW-1:0]     tof_o,
  output logic              overrun,
  output logic              timeout
);

  localparam int D  = 1 << LOG2D;
  localparam int AW = 2*W + LOG2D;
  localparam logic [TW-1:0]  TMAX    = {TW{1'b1}};
  localparam logic [CHW-1:0] LAST_CH = CHW'(N_CH - 1);

  typedef enum logic [1:0] {IDLE, PROC, DONE} state_t;

  state_t           state_q, state_d;
  logic [CHW-1:0]   ch_idx_q, ch_idx_d;
  logic             frame_load;

  logic [N_CH*W-1:0] frame_q;
  logic [AW-1:0]     acc_q   [N_CH];
  logic [2*W-1:0]    maf_buf [N_CH][D];
  logic [LOG2D-1:0]  wr_ptr_q;
  logic [TW-1:0]     timer_q;
  logic [N_CH-1:0]   armed_q;
  logic              rise_q;
  logic [CHW-1:0]    rise_ch_q;

  logic signed [W-1:0]   cur_sample;
  logic signed [2*W-1:0] sample_x, amp_x, prod;
  logic [2*W-1:0]        mag, old, env, low;
  logic [AW-1:0]         acc_new;
  logic                  det_cur, det_new, rise;

  assign ready = (state_q == IDLE);

  // ---------------- FSM ----------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      ch_idx_q <= '0;
    end else begin
      state_q  <= state_d;
      ch_idx_q <= ch_idx_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    ch_idx_d   = ch_idx_q;
    frame_load = 1'b0;
    case (state_q)
      IDLE: begin
        if (sample_valid) begin
          state_d    = PROC;
          ch_idx_d   = '0;
          frame_load = 1'b1;
        end
      end
      PROC: begin
        if (ch_idx_q == LAST_CH) state_d = DONE;
        else                     ch_idx_d = ch_idx_q + 1'b1;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // ---------------- shared datapath ----------------
  assign cur_sample = frame_q[ch_idx_q*W +: W];
  assign sample_x   = {{W{cur_sample[W-1]}}, cur_sample};
  assign amp_x      = {{W{amp[W-1]}}, amp};
  assign prod       = sample_x * amp_x;
  // |prod| <= 2^(2W-2), so the negation cannot wrap in 2W bits
  assign mag        = prod[2*W-1] ? unsigned'(-prod) : unsigned'(prod);
  assign old        = maf_buf[ch_idx_q][wr_ptr_q];
  assign acc_new    = acc_q[ch_idx_q] + {{LOG2D{1'b0}}, mag} - {{LOG2D{1'b0}}, old};
  assign env        = acc_new[AW-1:LOG2D];
  assign low        = (threshold > hyst) ? (threshold - hyst) : '0;
  assign det_cur    = det_o[ch_idx_q];

  always_comb begin
    det_new = det_cur;
    if (env > threshold)  det_new = 1'b1;
    else if (env < low)   det_new = 1'b0;
  end

  // a ping in the same cycle arms the channel being processed
  assign rise = (state_q == PROC) && !det_cur && det_new &&
                (armed_q[ch_idx_q] || ping_start);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_q  <= '0;
      wr_ptr_q <= '0;
      det_o    <= '0;
      for (int c = 0; c < N_CH; c++) begin
        acc_q[c] <= '0;
        for (int s = 0; s < D; s++) maf_buf[c][s] <= '0;
      end
    end else begin
      if (frame_load) frame_q <= sample_i;
      if (state_q == PROC) begin
        acc_q[ch_idx_q]             <= acc_new;
        maf_buf[ch_idx_q][wr_ptr_q] <= mag;
        det_o[ch_idx_q]             <= det_new;
      end
      if (state_q == DONE) wr_ptr_q <= wr_ptr_q + 1'b1;
    end
  end

  // ---------------- ToF timer, capture, sticky flags ----------------
  // The rise is registered first; the capture lands the cycle after det_o
  // goes high and samples the timer at that point.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      timer_q   <= '0;
      armed_q   <= '0;
      rise_q    <= 1'b0;
      rise_ch_q <= '0;
      tof_valid <= 1'b0;
      tof_ch    <= '0;
      tof_o     <= '0;
      overrun   <= 1'b0;
      timeout   <= 1'b0;
    end else begin
      rise_q    <= rise;
      if (rise) rise_ch_q <= ch_idx_q;
      tof_valid <= rise_q;
      if (rise_q) begin
        tof_ch <= rise_ch_q;
        tof_o  <= timer_q;
      end
      if (ping_start) begin
        timer_q <= '0;
        armed_q <= '1;
        timeout <= 1'b0;
        overrun <= 1'b0;
      end else begin
        if (state_q == DONE && timer_q != TMAX) begin
          timer_q <= timer_q + 1'b1;
          if (timer_q == TMAX - 1'b1) timeout <= 1'b1;
        end
        if (sample_valid && state_q != IDLE) overrun <= 1'b1;
        if (rise_q) armed_q[rise_ch_q] <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_sonar_echo_detector.sv
`timescale 1ns/1ps
module tb_sonar_echo_detector;

  localparam int N   = 4;
  localparam int W   = 16;
  localparam int LD  = 3;
  localparam int D   = 8;
  localparam int TW  = 4;
  localparam int TMAX = 15;
  localparam int CHW = 2;

  logic              clk;
  logic              rst_n;
  logic              sample_valid;
  logic [N*W-1:0]    sample_i;
  logic [W-1:0]      amp;
  logic [2*W-1:0]    threshold;
  logic [2*W-1:0]    hyst;
  logic              ping_start;
  logic              ready;
  logic [N-1:0]      det_o;
  logic              tof_valid;
  logic [CHW-1:0]    tof_ch;
  logic [TW-1:0]     tof_o;
  logic              overrun;
  logic              timeout;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  bit cmp_en   = 0;

  sonar_echo_detector #(.N_CH(N), .W(W), .LOG2D(LD), .TW(TW)) dut (
    .clk(clk), .rst_n(rst_n), .sample_valid(sample_valid), .sample_i(sample_i),
    .amp(amp), .threshold(threshold), .hyst(hyst), .ping_start(ping_start),
    .ready(ready), .det_o(det_o), .tof_valid(tof_valid), .tof_ch(tof_ch),
    .tof_o(tof_o), .overrun(overrun), .timeout(timeout)
  );

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Each channel keeps its last D magnitudes; the envelope is simply their
  // sum divided by D. phase 0 = idle, 1..N = channel phase-1, N+1 = wrap-up.
  longint     hist [N][D];
  int         m_phase, m_wp, m_timer, m_pend_ch, m_tof_ch, m_tof_o;
  logic [N*W-1:0] m_frame;
  logic [N-1:0]   m_det, m_armed;
  bit         m_timeout, m_overrun, m_pend, m_tof_valid;

  task automatic model_reset();
    for (int c = 0; c < N; c++)
      for (int s = 0; s < D; s++) hist[c][s] = 0;
    m_phase = 0; m_wp = 0; m_timer = 0; m_frame = '0;
    m_det = '0; m_armed = '0; m_timeout = 0; m_overrun = 0;
    m_pend = 0; m_pend_ch = 0; m_tof_valid = 0; m_tof_ch = 0; m_tof_o = 0;
  endtask

  task automatic model_step();
    bit rise;
    int rch, ch;
    longint p, mag, sum, env, thr, hy, lo;
    logic signed [W-1:0] s;
    logic nd;
    if (!rst_n) begin
      model_reset();
      return;
    end
    m_tof_valid = m_pend;
    if (m_pend) begin
      m_tof_ch = m_pend_ch;
      m_tof_o  = m_timer;
    end
    rise = 0; rch = 0;
    if (m_phase >= 1 && m_phase <= N) begin
      ch  = m_phase - 1;
      s   = m_frame[ch*W +: W];
      p   = longint'(s) * longint'($signed(amp));
      mag = (p < 0) ? -p : p;
      hist[ch][m_wp] = mag;
      sum = 0;
      for (int k = 0; k < D; k++) sum += hist[ch][k];
      env = sum / D;
      thr = threshold;
      hy  = hyst;
      lo  = (thr > hy) ? thr - hy : 0;
      nd  = m_det[ch];
      if (env > thr)     nd = 1'b1;
      else if (env < lo) nd = 1'b0;
      rise = !m_det[ch] && nd && (m_armed[ch] || ping_start);
      rch  = ch;
      m_det[ch] = nd;
    end
    if (m_pend) m_armed[m_pend_ch] = 1'b0;
    m_pend = rise;
    if (rise) m_pend_ch = rch;
    if (m_phase == N + 1) begin
      m_wp = (m_wp + 1) % D;
      if (m_timer < TMAX) begin
        m_timer++;
        if (m_timer == TMAX) m_timeout = 1;
      end
    end
    if (sample_valid && m_phase != 0) m_overrun = 1;
    if (m_phase == 0) begin
      if (sample_valid) begin
        m_frame = sample_i;
        m_phase = 1;
      end
    end else if (m_phase == N + 1) m_phase = 0;
    else m_phase++;
    if (ping_start) begin
      m_timer = 0; m_armed = '1; m_timeout = 0; m_overrun = 0;
    end
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk or negedge rst_n);
      model_step();
    end
  end

  initial forever begin
    @(negedge clk);
    if (cmp_en) begin
      chk("ready",     ready,     (m_phase == 0));
      chk("det_o",     det_o,     m_det);
      chk("tof_valid", tof_valid, m_tof_valid);
      chk("tof_ch",    tof_ch,    m_tof_ch);
      chk("tof_o",     tof_o,     m_tof_o);
      chk("overrun",   overrun,   m_overrun);
      chk("timeout",   timeout,   m_timeout);
    end
  end

  // capture log for the directed literal checks
  int ev_ch[$], ev_tof[$], ev_cyc[$];
  initial forever begin
    @(negedge clk);
    if (tof_valid === 1'b1) begin
      ev_ch.push_back(int'(tof_ch));
      ev_tof.push_back(int'(tof_o));
      ev_cyc.push_back(cyc);
    end
  end

  task automatic ev_clear();
    ev_ch.delete(); ev_tof.delete(); ev_cyc.delete();
  endtask

  function automatic logic [N*W-1:0] mk4(input int a, input int b, input int c, input int d);
    logic [N*W-1:0] r;
    r = {d[W-1:0], c[W-1:0], b[W-1:0], a[W-1:0]};
    return r;
  endfunction

  task automatic send_frame(input logic [N*W-1:0] s, output int lat);
    int n;
    n = 0;
    while (ready !== 1'b1 && n < 40) begin @(posedge clk); #1; n++; end
    if (ready !== 1'b1) chk("ready_before_frame", ready, 1);
    sample_i = s;
    sample_valid = 1;
    @(posedge clk); #1;
    sample_valid = 0;
    lat = 0;
    while (ready !== 1'b1 && lat < 40) begin @(posedge clk); #1; lat++; end
    if (ready !== 1'b1) chk("ready_after_frame", ready, 1);
  endtask

  task automatic ping();
    ping_start = 1;
    @(posedge clk); #1;
    ping_start = 0;
  endtask

  task automatic chk_reset_vals(input string pfx);
    chk({pfx, "_ready"},     ready,     1);
    chk({pfx, "_det_o"},     det_o,     0);
    chk({pfx, "_tof_valid"}, tof_valid, 0);
    chk({pfx, "_tof_ch"},    tof_ch,    0);
    chk({pfx, "_tof_o"},     tof_o,     0);
    chk({pfx, "_overrun"},   overrun,   0);
    chk({pfx, "_timeout"},   timeout,   0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    rst_n = 0; sample_valid = 0; sample_i = '0; amp = 16'd1;
    threshold = 32'd100; hyst = 32'd0; ping_start = 0;
    repeat (2) @(posedge clk);
    #1;
    cmp_en = 1;
    chk_reset_vals("reset");
    rst_n = 1;
    @(posedge clk); #1;

    // all-zero frame, unit gain
    ev_clear();
    send_frame(mk4(0, 0, 0, 0), lat);
    chk("zero_frame_latency", lat, 5);
    repeat (4) @(posedge clk);
    #1;
    chk("zero_frame_no_tof", ev_ch.size(), 0);
    chk("zero_frame_det", det_o, 0);

    // ch1 ramp: mag 2000 per frame, env = 250*(f+1). The ping follows frame 0,
    // so frame 6 (env 1750) is frame 5 since the ping and captures tof_o=5.
    amp = 16'd2; threshold = 32'd1500; hyst = 32'd0;
    ev_clear();
    for (int f = 0; f < 8; f++) begin
      send_frame(mk4(0, 1000, 0, 0), lat);
      chk($sformatf("ramp_det1_f%0d", f), det_o[1], (f >= 6));
      if (f == 0) ping();
    end
    repeat (3) @(posedge clk);
    #1;
    chk("ramp_tof_count", ev_ch.size(), 1);
    if (ev_ch.size() >= 1) begin
      chk("ramp_tof_ch", ev_ch[0], 1);
      chk("ramp_tof_o",  ev_tof[0], 5);
    end

    // hysteresis on ch2: env 1200 -> 900 -> 650, low = 700
    amp = 16'd1; threshold = 32'd1000; hyst = 32'd300;
    for (int f = 0; f < 8; f++) send_frame(mk4(0, 0, 1200, 0), lat);
    chk("hyst_det_at_1200", det_o[2], 1);
    for (int f = 0; f < 8; f++) send_frame(mk4(0, 0, 900, 0), lat);
    chk("hyst_hold_at_900", det_o[2], 1);
    for (int f = 0; f < 8; f++) begin
      send_frame(mk4(0, 0, 650, 0), lat);
      if (f == 5) chk("hyst_hold_at_712", det_o[2], 1);
      if (f == 6) chk("hyst_clear_at_681", det_o[2], 0);
    end

    // clamp: hyst > threshold gives low = 0, det never clears
    threshold = 32'd500; hyst = 32'd800;
    for (int f = 0; f < 8; f++) send_frame(mk4(0, 0, 0, 1000), lat);
    chk("clamp_det_set", det_o[3], 1);
    for (int f = 0; f < 8; f++) send_frame(mk4(0, 0, 0, 0), lat);
    chk("clamp_det_hold", det_o[3], 1);

    // extreme magnitude: (-32768)^2 = 2^30 on every channel
    amp = 16'h8000; threshold = 32'h3FFF_FFFF; hyst = 32'd0;
    for (int f = 0; f < 8; f++) send_frame(mk4(-32768, -32768, -32768, -32768), lat);
    chk("extreme_det_all", det_o, 4'hF);

    // sample_valid held high: busy frames are dropped
    amp = 16'd1; threshold = 32'd2000; hyst = 32'd100;
    sample_valid = 1;
    for (int c = 0; c < 40; c++) begin
      sample_i = mk4(int'($urandom_range(0, 4000)), int'($urandom_range(0, 4000)),
                     int'($urandom_range(0, 4000)), int'($urandom_range(0, 4000)));
      @(posedge clk); #1;
    end
    sample_valid = 0;
    repeat (8) @(posedge clk);
    #1;
    chk("stream_overrun", overrun, 1);
    ping();
    chk("ping_clears_overrun", overrun, 0);

    // ping coincident with DONE, then ch0 and ch1 detect in one frame
    amp = 16'd1; threshold = 32'd100; hyst = 32'd0;
    for (int f = 0; f < 8; f++) send_frame(mk4(0, 0, 0, 0), lat);
    chk("pre_pair_det", det_o, 0);
    sample_i = '0;
    sample_valid = 1;
    @(posedge clk); #1;
    sample_valid = 0;
    repeat (N) begin @(posedge clk); #1; end
    chk("in_done_ready", ready, 0);
    ping();
    chk("after_done_ready", ready, 1);
    ev_clear();
    send_frame(mk4(8000, 8000, 0, 0), lat);
    repeat (3) @(posedge clk);
    #1;
    chk("pair_count", ev_ch.size(), 2);
    if (ev_ch.size() == 2) begin
      chk("pair_first_ch",  ev_ch[0], 0);
      chk("pair_second_ch", ev_ch[1], 1);
      chk("pair_adjacent",  ev_cyc[1] - ev_cyc[0], 1);
      chk("pair_tof0",      ev_tof[0], 0);
      chk("pair_tof1",      ev_tof[1], 0);
    end

    // timer saturation at 2^TW-1 = 15 frames
    ping();
    for (int k = 1; k <= 15; k++) begin
      send_frame(mk4(0, 0, 0, 0), lat);
      if (k == 14) chk("timeout_before_sat", timeout, 0);
      if (k == 15) chk("timeout_at_sat", timeout, 1);
    end
    ping();
    chk("ping_clears_timeout", timeout, 0);

    // asynchronous reset in the middle of PROC
    threshold = 32'd100; amp = 16'd1;
    sample_i = mk4(8000, 8000, 8000, 8000);
    sample_valid = 1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    sample_valid = 0;
    @(posedge clk); #1;
    chk("pre_rst_overrun",   overrun,   1);
    chk("pre_rst_ready",     ready,     0);
    chk("pre_rst_tof_valid", tof_valid, 1);
    #1 rst_n = 0;
    #1;
    chk_reset_vals("midproc_reset");
    @(posedge clk); #1;
    rst_n = 1;
    @(posedge clk); #1;

    // randomized traffic against the model
    for (int c = 0; c < 3000; c++) begin
      if (ready === 1'b1 && $urandom_range(0, 9) == 0) begin
        int a;
        a = int'($urandom_range(0, 6)) - 3;
        amp = a[W-1:0];
        threshold = 32'($urandom_range(0, 8000));
        hyst = 32'($urandom_range(0, 3000));
      end
      for (int k = 0; k < N; k++) begin
        int v;
        v = int'($urandom_range(0, 8000)) - 4000;
        sample_i[k*W +: W] = v[W-1:0];
      end
      sample_valid = ($urandom_range(0, 3) == 0);
      ping_start = ($urandom_range(0, 80) == 0);
      @(posedge clk); #1;
    end
    sample_valid = 0;
    ping_start = 0;
    repeat (10) @(posedge clk);
    #1;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
